// File: rtl/typedefs_pkg.sv
// Shared types for the pipelined data memory: RV32 access sizes, controller states,
// the response pipeline record and the request legality check.
package typedefs_pkg;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } mem_size_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } dmem_state_t;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    // Unsigned sizes only make sense for loads; 011/110/111 are never legal.
    function automatic logic size_error(input logic       we,
                                        input logic [2:0] size,
                                        input logic [1:0] off);
        logic e;
        case (size)
            SZ_B:    e = 1'b0;
            SZ_H:    e = off[0];
            SZ_W:    e = |off;
            SZ_BU:   e = we;
            SZ_HU:   e = we | off[0];
            default: e = 1'b1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering between a 32-bit memory word and right-aligned RV32 data:
// load lane selection with sign/zero extension, and store lane mask/data placement.
module mem_align
    import typedefs_pkg::*;
(
    input  logic [31:0] rword_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  size_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic [3:0]  wmask_o,
    output logic [31:0] wdata_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rword_i >> {off_i, 3'b000};
        rdata_o = '0;
        case (size_i)
            SZ_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
            SZ_H:    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
            SZ_W:    rdata_o = rword_i;
            SZ_BU:   rdata_o = {24'h0, shifted[7:0]};
            SZ_HU:   rdata_o = {16'h0, shifted[15:0]};
            default: rdata_o = '0;
        endcase
    end

    always_comb begin
        wdata_o = wdata_i << {off_i, 3'b000};
        wmask_o = '0;
        case (size_i)
            SZ_B:    wmask_o = 4'b0001 << off_i;
            SZ_H:    wmask_o = 4'b0011 << off_i;
            SZ_W:    wmask_o = 4'b1111;
            default: wmask_o = '0;
        endcase
    end

endmodule

// File: rtl/pipelined_data_mem.sv
// Byte-addressable data memory with self-clearing init, RV32 load/store sizes and a
// fixed-latency in-order response pipeline.
module pipelined_data_mem
    import typedefs_pkg::*;
#(
    parameter int AWIDTH  = 10,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_size,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int WAW    = AWIDTH - 2;
    localparam int NWORDS = 1 << WAW;

    dmem_state_t    state_q, state_d;
    logic [WAW-1:0] cnt_q, cnt_d;
    logic [31:0]    mem_q [NWORDS];
    rsp_t           pipe_q [LATENCY];
    rsp_t           rsp_new;

    logic           accept;
    logic           req_err;
    logic           do_store;
    logic [WAW-1:0] word_idx;
    logic [31:0]    rd_word;
    logic [31:0]    ld_data;
    logic [31:0]    st_data;
    logic [3:0]     st_mask;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = RUN;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready = (state_q == RUN) && !rst;
    assign init_done = (state_q == RUN) && !rst;
    assign accept    = req_valid && req_ready;
    assign req_err   = size_error(req_we, req_size, req_addr[1:0]);
    assign do_store  = accept && req_we && !req_err;
    assign word_idx  = req_addr[AWIDTH-1:2];
    assign rd_word   = mem_q[word_idx];

    mem_align u_align (
        .rword_i (rd_word),
        .off_i   (req_addr[1:0]),
        .size_i  (req_size),
        .wdata_i (req_wdata),
        .rdata_o (ld_data),
        .wmask_o (st_mask),
        .wdata_o (st_data)
    );

    // The clear sweep owns the write port during INIT; stores only land in RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == INIT) begin
                mem_q[cnt_q] <= '0;
            end else if (do_store) begin
                for (int b = 0; b < 4; b++) begin
                    if (st_mask[b]) begin
                        mem_q[word_idx][8*b +: 8] <= st_data[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        rsp_new       = '0;
        rsp_new.valid = accept;
        rsp_new.err   = accept && req_err;
        if (accept && !req_we && !req_err) begin
            rsp_new.data = ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= rsp_new;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign rsp_valid = pipe_q[LATENCY-1].valid && !rst;
    assign rsp_err   = pipe_q[LATENCY-1].err && !rst;
    assign rsp_rdata = rst ? 32'h0 : pipe_q[LATENCY-1].data;

endmodule

// File: tb/tb_pipelined_data_mem.sv
// Directed, table-driven bench for pipelined_data_mem (AWIDTH = 10, LATENCY = 3):
// init sweep, sized loads/stores, error cases, back-to-back pipelining, mid-stream reset.
module tb_pipelined_data_mem;

    localparam int LAT = 3;

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] expData;
        logic        expErr;
        string       name;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_size;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_done;

    int checks = 0;
    int errors = 0;

    vec_t        vecs[$];
    logic        pipeWe[16];
    logic [9:0]  pipeAddr[16];
    logic [31:0] pipeWdata[16];
    logic [31:0] pipeExp[16];

    pipelined_data_mem #(
        .AWIDTH  (10),
        .LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(input logic we, input logic [2:0] size, input logic [9:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] expData,
                                   input logic expErr, input string name);
        vec_t v;
        v.we      = we;
        v.size    = size;
        v.addr    = addr;
        v.wdata   = wdata;
        v.expData = expData;
        v.expErr  = expErr;
        v.name    = name;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic driveReq(input logic we, input logic [2:0] size, input logic [9:0] addr,
                            input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    // Entered just after the acceptance edge; the response must show up at the LAT-th negedge.
    task automatic waitResponse(input string name, input logic [31:0] expData, input logic expErr);
        int          firstAt;
        logic [31:0] gotData;
        logic        gotErr;
        firstAt   = 0;
        gotData   = '0;
        gotErr    = 1'b0;
        req_valid = 1'b0;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            if (rsp_valid && firstAt == 0) begin
                firstAt = k;
                gotData = rsp_rdata;
                gotErr  = rsp_err;
            end
        end
        checkOutput({name, "_latency"}, 32'(firstAt), 32'(LAT));
        checkOutput({name, "_rdata"}, gotData, expData);
        checkOutput({name, "_err"}, 32'(gotErr), 32'(expErr));
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        driveReq(v.we, v.size, v.addr, v.wdata);
        @(negedge clk);
        checkOutput({v.name, "_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        waitResponse(v.name, v.expData, v.expErr);
    endtask

    task automatic initSequence(input string tag);
        int notReady;
        int badSeen;
        rst = 1'b1;
        driveReq(1'b0, 3'b010, 10'h000, 32'h0);
        @(negedge clk);
        checkOutput({tag, "_rst_ready"}, 32'(req_ready), 32'd0);
        checkOutput({tag, "_rst_init_done"}, 32'(init_done), 32'd0);
        checkOutput({tag, "_rst_rsp_valid"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, "_rst_rsp_rdata"}, rsp_rdata, 32'd0);
        checkOutput({tag, "_rst_rsp_err"}, 32'(rsp_err), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput({tag, "_rst_rsp_valid2"}, 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        notReady = 0;
        badSeen  = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (req_ready) break;
            notReady++;
            if (init_done || rsp_valid) badSeen++;
            @(posedge clk);
            #1;
        end
        checkOutput({tag, "_not_ready_cycles"}, 32'(notReady), 32'd256);
        checkOutput({tag, "_quiet_during_init"}, 32'(badSeen), 32'd0);
        checkOutput({tag, "_init_done"}, 32'(init_done), 32'd1);
        @(posedge clk);
        #1;
        waitResponse({tag, "_lw_000"}, 32'h0, 1'b0);
    endtask

    initial begin
        int r;
        logic expV;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = 3'b000;
        req_addr  = '0;
        req_wdata = '0;

        vecs.push_back(mkVec(1'b1, 3'b010, 10'h010, 32'h00000000, 32'h00000000, 1'b0, "sw_010"));
        vecs.push_back(mkVec(1'b1, 3'b000, 10'h012, 32'h00000080, 32'h00000000, 1'b0, "sb_012"));
        vecs.push_back(mkVec(1'b0, 3'b000, 10'h012, 32'hFFFFFFFF, 32'hFFFFFF80, 1'b0, "lb_012"));
        vecs.push_back(mkVec(1'b0, 3'b100, 10'h012, 32'hFFFFFFFF, 32'h00000080, 1'b0, "lbu_012"));
        vecs.push_back(mkVec(1'b0, 3'b010, 10'h010, 32'h00000000, 32'h00800000, 1'b0, "lw_010"));
        vecs.push_back(mkVec(1'b1, 3'b001, 10'h006, 32'h1234BEEF, 32'h00000000, 1'b0, "sh_006"));
        vecs.push_back(mkVec(1'b0, 3'b001, 10'h006, 32'h00000000, 32'hFFFFBEEF, 1'b0, "lh_006"));
        vecs.push_back(mkVec(1'b0, 3'b101, 10'h006, 32'h00000000, 32'h0000BEEF, 1'b0, "lhu_006"));
        vecs.push_back(mkVec(1'b0, 3'b010, 10'h004, 32'h00000000, 32'hBEEF0000, 1'b0, "lw_004"));
        vecs.push_back(mkVec(1'b0, 3'b010, 10'h002, 32'h00000000, 32'h00000000, 1'b1, "lw_mis_002"));
        vecs.push_back(mkVec(1'b1, 3'b001, 10'h001, 32'h00001234, 32'h00000000, 1'b1, "sh_mis_001"));
        vecs.push_back(mkVec(1'b1, 3'b100, 10'h010, 32'h00000055, 32'h00000000, 1'b1, "sbu_ill"));
        vecs.push_back(mkVec(1'b1, 3'b101, 10'h004, 32'h00007777, 32'h00000000, 1'b1, "shu_ill"));
        vecs.push_back(mkVec(1'b1, 3'b110, 10'h000, 32'hFFFFFFFF, 32'h00000000, 1'b1, "st_size110"));
        vecs.push_back(mkVec(1'b0, 3'b011, 10'h000, 32'h00000000, 32'h00000000, 1'b1, "ld_size011"));
        vecs.push_back(mkVec(1'b0, 3'b111, 10'h010, 32'h00000000, 32'h00000000, 1'b1, "ld_size111"));
        vecs.push_back(mkVec(1'b0, 3'b010, 10'h010, 32'h00000000, 32'h00800000, 1'b0, "lw_010_kept"));
        vecs.push_back(mkVec(1'b0, 3'b010, 10'h000, 32'h00000000, 32'h00000000, 1'b0, "lw_000_kept"));
        vecs.push_back(mkVec(1'b0, 3'b010, 10'h004, 32'h00000000, 32'hBEEF0000, 1'b0, "lw_004_kept"));
        vecs.push_back(mkVec(1'b1, 3'b000, 10'h011, 32'hFFFFFF7F, 32'h00000000, 1'b0, "sb_011"));
        vecs.push_back(mkVec(1'b0, 3'b000, 10'h011, 32'h00000000, 32'h0000007F, 1'b0, "lb_011"));
        vecs.push_back(mkVec(1'b0, 3'b010, 10'h010, 32'h00000000, 32'h00807F00, 1'b0, "lw_010_lanes"));
        vecs.push_back(mkVec(1'b1, 3'b010, 10'h3FC, 32'hDEADBEEF, 32'h00000000, 1'b0, "sw_3fc"));
        vecs.push_back(mkVec(1'b0, 3'b000, 10'h3FF, 32'h00000000, 32'hFFFFFFDE, 1'b0, "lb_3ff"));
        vecs.push_back(mkVec(1'b0, 3'b101, 10'h3FE, 32'h00000000, 32'h0000DEAD, 1'b0, "lhu_3fe"));
        vecs.push_back(mkVec(1'b0, 3'b001, 10'h3FC, 32'h00000000, 32'hFFFFBEEF, 1'b0, "lh_3fc"));
        vecs.push_back(mkVec(1'b0, 3'b100, 10'h3FD, 32'h00000000, 32'h000000BE, 1'b0, "lbu_3fd"));
        vecs.push_back(mkVec(1'b0, 3'b001, 10'h003, 32'h00000000, 32'h00000000, 1'b1, "lh_mis_003"));

        for (int j = 0; j < 8; j++) begin
            pipeWe[2*j]      = 1'b1;
            pipeAddr[2*j]    = 10'h100 + 10'(4*j);
            pipeWdata[2*j]   = 32'hC0DE0000 + 32'(j) * 32'h00001111;
            pipeExp[2*j]     = 32'h0;
            pipeWe[2*j+1]    = 1'b0;
            pipeAddr[2*j+1]  = 10'h100 + 10'(4*j);
            pipeWdata[2*j+1] = 32'h0;
            pipeExp[2*j+1]   = 32'hC0DE0000 + 32'(j) * 32'h00001111;
        end

        @(posedge clk);
        #1;
        initSequence("init");

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
        end

        for (int n = 0; n < 16 + LAT + 2; n++) begin
            if (n < 16) begin
                driveReq(pipeWe[n], 3'b010, pipeAddr[n], pipeWdata[n]);
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            if (n < 16) begin
                checkOutput($sformatf("pipe_ready_%0d", n), 32'(req_ready), 32'd1);
            end
            r    = n - LAT;
            expV = (r >= 0) && (r < 16);
            checkOutput($sformatf("pipe_valid_%0d", n), 32'(rsp_valid), 32'(expV));
            if (expV) begin
                checkOutput($sformatf("pipe_rdata_%0d", r), rsp_rdata, pipeExp[r]);
                checkOutput($sformatf("pipe_err_%0d", r), 32'(rsp_err), 32'd0);
            end
            @(posedge clk);
            #1;
        end

        driveReq(1'b0, 3'b010, 10'h100, 32'h0);
        @(posedge clk);
        #1;
        driveReq(1'b0, 3'b010, 10'h104, 32'h0);
        @(posedge clk);
        #1;
        initSequence("reinit");
        applyStimulus(mkVec(1'b0, 3'b010, 10'h100, 32'h0, 32'h0, 1'b0, "lw_100_cleared"));
        applyStimulus(mkVec(1'b0, 3'b010, 10'h104, 32'h0, 32'h0, 1'b0, "lw_104_cleared"));
        applyStimulus(mkVec(1'b0, 3'b010, 10'h010, 32'h0, 32'h0, 1'b0, "lw_010_cleared"));
        applyStimulus(mkVec(1'b0, 3'b010, 10'h3FC, 32'h0, 32'h0, 1'b0, "lw_3fc_cleared"));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
